// File: rtl/c4_move_controller.sv
`default_nettype none
// ============================================================================
// Module   : c4_move_controller
// Connect-4 game flow: cursor column, column fill counts, turn and draw strobe.
// Revision : 1.0
// ============================================================================
module c4_move_controller #(
    parameter int START_COL    = 3,
    parameter int ROWS         = 6,
    parameter int SETUP_CYCLES = 2,
    parameter int DRAW_CYCLES  = 66
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       drop,
    output logic [2:0] currCol,
    output logic [2:0] colCount0,
    output logic [2:0] colCount1,
    output logic [2:0] colCount2,
    output logic [2:0] colCount3,
    output logic [2:0] colCount4,
    output logic [2:0] colCount5,
    output logic [2:0] colCount6,
    output logic       P1_turn,
    output logic       P2_turn,
    output logic       place,
    output logic       busy,
    output logic       game_over
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] DRAW   = 3'd2;
    localparam logic [2:0] COMMIT = 3'd3;
    localparam logic [2:0] OVER   = 3'd4;

    localparam logic [2:0] MAX_COL    = 3'd6;
    localparam logic [2:0] FULL       = 3'(ROWS);
    localparam logic [6:0] SETUP_LAST = 7'(SETUP_CYCLES - 1);
    localparam logic [6:0] DRAW_LAST  = 7'(DRAW_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [6:0] cnt;
    logic       prev_left;
    logic       prev_right;
    logic       prev_drop;
    logic       left_edge;
    logic       right_edge;
    logic       drop_edge;
    logic [2:0] col_count [7];
    logic       turn;
    logic       col_full;
    logic       board_full_next;

    assign left_edge  = move_left  & ~prev_left;
    assign right_edge = move_right & ~prev_right;
    assign drop_edge  = drop       & ~prev_drop;
    assign col_full   = (col_count[currCol] >= FULL);

    // Board is full after this commit if the cursor column reaches FULL and all others already are.
    always_comb begin
        board_full_next = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (3'(c) == currCol) begin
                if (col_count[c] + 3'd1 != FULL) board_full_next = 1'b0;
            end else if (col_count[c] != FULL) begin
                board_full_next = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= IDLE;
            cnt   <= 7'd0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cnt <= 7'd0;
            else if (state == SETUP || state == DRAW)
                cnt <= cnt + 7'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (drop_edge && !col_full) next_state = SETUP;
            SETUP:   if (cnt == SETUP_LAST) next_state = DRAW;
            DRAW:    if (cnt == DRAW_LAST) next_state = COMMIT;
            COMMIT:  next_state = board_full_next ? OVER : IDLE;
            OVER:    next_state = OVER;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        place     = (state == DRAW);
        busy      = (state == SETUP) || (state == DRAW) || (state == COMMIT);
        game_over = (state == OVER);
    end

    // Edge history keeps tracking in every state so buttons held through a draw do not re-fire.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            prev_left  <= 1'b0;
            prev_right <= 1'b0;
            prev_drop  <= 1'b0;
            currCol    <= 3'(START_COL);
            turn       <= 1'b1;
            for (int c = 0; c < 7; c++) col_count[c] <= 3'd0;
        end else begin
            prev_left  <= move_left;
            prev_right <= move_right;
            prev_drop  <= drop;
            if (state == IDLE && !drop_edge) begin
                if (left_edge && !right_edge && currCol != 3'd0)
                    currCol <= currCol - 3'd1;
                else if (right_edge && !left_edge && currCol != MAX_COL)
                    currCol <= currCol + 3'd1;
            end
            if (state == COMMIT) begin
                if (col_count[currCol] < FULL)
                    col_count[currCol] <= col_count[currCol] + 3'd1;
                turn <= ~turn;
            end
        end
    end

    assign P1_turn   = turn;
    assign P2_turn   = ~turn;
    assign colCount0 = col_count[0];
    assign colCount1 = col_count[1];
    assign colCount2 = col_count[2];
    assign colCount3 = col_count[3];
    assign colCount4 = col_count[4];
    assign colCount5 = col_count[5];
    assign colCount6 = col_count[6];

endmodule
`default_nettype wire

// File: tb/tb_c4_move_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_c4_move_controller
// Directed self-checking bench for c4_move_controller.
// Revision : 1.0
// ============================================================================
module tb_c4_move_controller;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic       drop = 1'b0;
    logic [2:0] currCol;
    logic [2:0] cc [7];
    logic       P1_turn;
    logic       P2_turn;
    logic       place;
    logic       busy;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int exp_col = 3;

    c4_move_controller #(
        .START_COL(3), .ROWS(6), .SETUP_CYCLES(2), .DRAW_CYCLES(66)
    ) dut (
        .Clock(Clock), .Resetn(Resetn),
        .move_left(move_left), .move_right(move_right), .drop(drop),
        .currCol(currCol),
        .colCount0(cc[0]), .colCount1(cc[1]), .colCount2(cc[2]), .colCount3(cc[3]),
        .colCount4(cc[4]), .colCount5(cc[5]), .colCount6(cc[6]),
        .P1_turn(P1_turn), .P2_turn(P2_turn),
        .place(place), .busy(busy), .game_over(game_over)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // which: 0 = left, 1 = right, 2 = drop
    task automatic press(input int which);
        if (which == 0) move_left = 1'b1;
        else if (which == 1) move_right = 1'b1;
        else drop = 1'b1;
        tick();
        move_left = 1'b0;
        move_right = 1'b0;
        drop = 1'b0;
        tick();
    endtask

    task automatic move_to(input int target);
        while (exp_col < target) begin press(1); exp_col++; end
        while (exp_col > target) begin press(0); exp_col--; end
        check("move_to", currCol, exp_col);
    endtask

    task automatic do_drop();
        int n;
        drop = 1'b1;
        tick();
        drop = 1'b0;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        if (n >= 100) check("drop_timeout", 1, 0);
    endtask

    task automatic apply_reset();
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
        exp_col = 3;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int frozen_bad;

        // Reset state
        apply_reset();
        check("rst_col", currCol, 3);
        for (int c = 0; c < 7; c++) check("rst_count", cc[c], 0);
        check("rst_p1", P1_turn, 1);
        check("rst_p2", P2_turn, 0);
        check("rst_place", place, 0);
        check("rst_busy", busy, 0);
        check("rst_over", game_over, 0);

        // Cursor saturation at both ends
        begin
            int exp_left [5] = '{2, 1, 0, 0, 0};
            for (int i = 0; i < 5; i++) begin
                press(0);
                check("left_sat", currCol, exp_left[i]);
            end
        end
        for (int i = 0; i < 8; i++) press(1);
        check("right_sat", currCol, 6);
        exp_col = 6;
        move_to(3);
        move_left = 1'b1;
        move_right = 1'b1;
        tick();
        move_left = 1'b0;
        move_right = 1'b0;
        tick();
        check("both_no_move", currCol, 3);

        // Drop timing at column 3
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check("setup1_place", place, 0);
        check("setup1_busy", busy, 1);
        tick();
        check("setup2_place", place, 0);
        tick();
        check("draw_first", place, 1);
        n = 0;
        frozen_bad = 0;
        while (place && n < 200) begin
            if (cc[3] != 0 || P1_turn != 1 || currCol != 3) frozen_bad++;
            n++;
            tick();
        end
        check("draw_len", n, 66);
        check("draw_frozen", frozen_bad, 0);
        check("commit_count", cc[3], 0);
        check("commit_busy", busy, 1);
        tick();
        check("after_count3", cc[3], 1);
        check("after_p1", P1_turn, 0);
        check("after_p2", P2_turn, 1);
        check("after_busy", busy, 0);

        // Column 0: presses during DRAW are discarded
        move_to(0);
        drop = 1'b1;
        tick();
        drop = 1'b0;
        repeat (10) tick();
        check("mid_draw", place, 1);
        move_right = 1'b1;
        drop = 1'b1;
        tick();
        move_right = 1'b0;
        drop = 1'b0;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        check("draw_press_col", currCol, 0);
        check("draw_press_cnt", cc[0], 1);
        tick();
        tick();
        check("no_queued_drop", busy, 0);
        for (int i = 0; i < 5; i++) do_drop();
        check("col0_full", cc[0], 6);
        check("col0_turn", P1_turn, 0);

        // Seventh drop into full column is ignored
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check("full_busy", busy, 0);
        tick();
        tick();
        tick();
        check("full_place", place, 0);
        check("full_busy2", busy, 0);
        check("full_turn", P1_turn, 0);
        check("full_cnt", cc[0], 6);

        // Fill the remaining board
        for (int c = 1; c < 7; c++) begin
            move_to(c);
            for (int k = 0; k < ((c == 3) ? 5 : 6); k++) begin
                if (c == 6 && k == 5) check("not_over_yet", game_over, 0);
                do_drop();
            end
            check("col_filled", cc[c], 6);
        end
        check("over", game_over, 1);
        check("over_busy", busy, 0);
        check("over_turn", P1_turn, 1);
        press(2);
        press(0);
        press(0);
        press(1);
        tick();
        check("over_col", currCol, 6);
        check("over_place", place, 0);
        check("over_busy2", busy, 0);
        check("over_hold", game_over, 1);
        check("over_cnt6", cc[6], 6);

        // Reset in the 30th place cycle
        apply_reset();
        check("rst2_over", game_over, 0);
        check("rst2_cnt0", cc[0], 0);
        drop = 1'b1;
        tick();
        drop = 1'b0;
        tick();
        tick();
        repeat (29) tick();
        check("place30", place, 1);
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        check("rst_mid_place", place, 0);
        check("rst_mid_cnt", cc[3], 0);
        check("rst_mid_p1", P1_turn, 1);
        check("rst_mid_busy", busy, 0);
        press(0);
        check("rst_mid_idle", currCol, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
